// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register followed by EX-stage RAW forwarding and ALU operand selection.
// Also hands the resolved destination, write-enable and store data on to EX/MEM.
module id_ex_operand_stage #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall_i,
    input  logic              flush_i,
    input  logic              id_valid_i,
    input  logic [DATA_W-1:0] id_rs_data_i,
    input  logic [DATA_W-1:0] id_rt_data_i,
    input  logic [DATA_W-1:0] id_imm_i,
    input  logic [REG_AW-1:0] id_rs_i,
    input  logic [REG_AW-1:0] id_rt_i,
    input  logic [REG_AW-1:0] id_rd_i,
    input  logic              id_regdst_i,
    input  logic              id_alusrc_i,
    input  logic [2:0]        id_aluop_i,
    input  logic              id_regwrite_i,
    input  logic              exmem_regwrite_i,
    input  logic [REG_AW-1:0] exmem_rd_i,
    input  logic [DATA_W-1:0] exmem_result_i,
    input  logic              memwb_regwrite_i,
    input  logic [REG_AW-1:0] memwb_rd_i,
    input  logic [DATA_W-1:0] memwb_result_i,
    output logic [DATA_W-1:0] operanda_o,
    output logic [DATA_W-1:0] operandb_o,
    output logic [2:0]        op_o,
    output logic [DATA_W-1:0] ex_storedata_o,
    output logic [REG_AW-1:0] ex_dest_o,
    output logic              ex_regwrite_o,
    output logic              ex_valid_o
);

    logic [DATA_W-1:0] rs_data_q, rs_data_d;
    logic [DATA_W-1:0] rt_data_q, rt_data_d;
    logic [DATA_W-1:0] imm_q, imm_d;
    logic [REG_AW-1:0] rs_q, rs_d;
    logic [REG_AW-1:0] rt_q, rt_d;
    logic [REG_AW-1:0] dest_q, dest_d;
    logic              alusrc_q, alusrc_d;
    logic [2:0]        aluop_q, aluop_d;
    logic              regwrite_q, regwrite_d;
    logic              valid_q, valid_d;

    logic [DATA_W-1:0] fwd_rs;
    logic [DATA_W-1:0] fwd_rt;

    // Next-state selection: flush beats stall, stall beats load.
    always_comb begin
        // NOTE: every next-state signal gets its hold value first so no path can infer a latch.
        rs_data_d  = rs_data_q;
        rt_data_d  = rt_data_q;
        imm_d      = imm_q;
        rs_d       = rs_q;
        rt_d       = rt_q;
        dest_d     = dest_q;
        alusrc_d   = alusrc_q;
        aluop_d    = aluop_q;
        regwrite_d = regwrite_q;
        valid_d    = valid_q;
        if (flush_i) begin
            rs_data_d  = '0;
            rt_data_d  = '0;
            imm_d      = '0;
            rs_d       = '0;
            rt_d       = '0;
            dest_d     = '0;
            alusrc_d   = 1'b0;
            aluop_d    = 3'b000;
            regwrite_d = 1'b0;
            valid_d    = 1'b0;
        end else if (!stall_i) begin
            rs_data_d  = id_rs_data_i;
            rt_data_d  = id_rt_data_i;
            imm_d      = id_imm_i;
            rs_d       = id_rs_i;
            rt_d       = id_rt_i;
            dest_d     = id_regdst_i ? id_rd_i : id_rt_i;
            alusrc_d   = id_alusrc_i;
            aluop_d    = id_aluop_i;
            regwrite_d = id_regwrite_i;
            valid_d    = id_valid_i;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rs_data_q  <= '0;
            rt_data_q  <= '0;
            imm_q      <= '0;
            rs_q       <= '0;
            rt_q       <= '0;
            dest_q     <= '0;
            alusrc_q   <= 1'b0;
            aluop_q    <= 3'b000;
            regwrite_q <= 1'b0;
            valid_q    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the pre-edge values.
            rs_data_q  <= rs_data_d;
            rt_data_q  <= rt_data_d;
            imm_q      <= imm_d;
            rs_q       <= rs_d;
            rt_q       <= rt_d;
            dest_q     <= dest_d;
            alusrc_q   <= alusrc_d;
            aluop_q    <= aluop_d;
            regwrite_q <= regwrite_d;
            valid_q    <= valid_d;
        end
    end

    // Forwarding stays live during a stall; EX/MEM is the younger result and wins over MEM/WB.
    always_comb begin
        fwd_rs = rs_data_q;
        if (exmem_regwrite_i && (exmem_rd_i != '0) && (exmem_rd_i == rs_q))
            fwd_rs = exmem_result_i;
        else if (memwb_regwrite_i && (memwb_rd_i != '0) && (memwb_rd_i == rs_q))
            fwd_rs = memwb_result_i;
    end

    always_comb begin
        fwd_rt = rt_data_q;
        if (exmem_regwrite_i && (exmem_rd_i != '0) && (exmem_rd_i == rt_q))
            fwd_rt = exmem_result_i;
        else if (memwb_regwrite_i && (memwb_rd_i != '0) && (memwb_rd_i == rt_q))
            fwd_rt = memwb_result_i;
    end

    assign operanda_o     = fwd_rs;
    assign operandb_o     = alusrc_q ? imm_q : fwd_rt;
    assign ex_storedata_o = fwd_rt;
    assign op_o           = aluop_q;
    assign ex_dest_o      = dest_q;
    assign ex_regwrite_o  = regwrite_q & valid_q;
    assign ex_valid_o     = valid_q;

endmodule
